// File: rtl/mprjram_arbiter.sv
// Round-robin arbiter sharing the single-port user-project BRAM between the
// Wishbone slave path and the accelerator master port.
module mprjram_arbiter #(
  parameter int          ADDR_W   = 12,
  parameter int          BRAM_LAT = 10,
  parameter logic [7:0]  BASE_HI  = 8'h38
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_i,
  input  logic              wbs_stb_i,
  input  logic              wbs_cyc_i,
  input  logic              wbs_we_i,
  input  logic [3:0]        wbs_sel_i,
  input  logic [31:0]       wbs_adr_i,
  input  logic [31:0]       wbs_dat_i,
  output logic              wbs_ack_o,
  output logic [31:0]       wbs_dat_o,
  input  logic              acc_req,
  input  logic              acc_we,
  input  logic [3:0]        acc_be,
  input  logic [ADDR_W-1:0] acc_addr,
  input  logic [31:0]       acc_wdata,
  output logic              acc_gnt,
  output logic              acc_done,
  output logic [31:0]       acc_rdata,
  output logic              bram_en,
  output logic [3:0]        bram_we,
  output logic [ADDR_W-1:0] bram_addr,
  output logic [31:0]       bram_wdata,
  input  logic [31:0]       bram_rdata,
  output logic              arb_busy
);

  // state  | meaning
  // IDLE   | no access in flight; arbitrate between requesters
  // ACCESS | single BRAM enable cycle with latched address/data
  // WAIT   | counting down the BRAM read latency
  // DONE   | completion pulse to the owner
  typedef enum logic [1:0] {IDLE, ACCESS, WAIT, DONE} state_t;

  state_t      state;
  logic        owner_acc;
  logic        last_acc;
  logic        we_q;
  logic [3:0]  cnt;
  logic        wb_req;
  logic        grant_acc;
  logic        complete;
  logic [31:0] done_data;
  logic        unused_ok;

  assign wb_req    = wbs_stb_i & wbs_cyc_i & (wbs_adr_i[31:24] == BASE_HI);
  // Accelerator wins when alone, or on a tie when Wishbone went last.
  assign grant_acc = acc_req & (~wb_req | ~last_acc);
  assign complete  = ((state == ACCESS) && we_q) || ((state == WAIT) && (cnt == 4'd0));
  assign done_data = we_q ? 32'd0 : bram_rdata;
  assign unused_ok = ^{wbs_adr_i[23:ADDR_W+2], wbs_adr_i[1:0]};

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state      <= IDLE;
      owner_acc  <= 1'b0;
      last_acc   <= 1'b1;
      we_q       <= 1'b0;
      cnt        <= 4'd0;
      wbs_ack_o  <= 1'b0;
      wbs_dat_o  <= 32'd0;
      acc_gnt    <= 1'b0;
      acc_done   <= 1'b0;
      acc_rdata  <= 32'd0;
      bram_en    <= 1'b0;
      bram_we    <= 4'd0;
      bram_addr  <= '0;
      bram_wdata <= 32'd0;
      arb_busy   <= 1'b0;
    end else begin
      bram_en   <= 1'b0;
      bram_we   <= 4'd0;
      acc_gnt   <= 1'b0;
      wbs_ack_o <= 1'b0;
      acc_done  <= 1'b0;

      if (complete) begin
        if (owner_acc) begin
          acc_done  <= 1'b1;
          acc_rdata <= done_data;
        end else begin
          wbs_ack_o <= 1'b1;
          wbs_dat_o <= done_data;
        end
      end

      case (state)
        IDLE: begin
          if (wb_req || acc_req) begin
            owner_acc <= grant_acc;
            last_acc  <= grant_acc;
            acc_gnt   <= grant_acc;
            bram_en   <= 1'b1;
            arb_busy  <= 1'b1;
            state     <= ACCESS;
            if (grant_acc) begin
              we_q       <= acc_we;
              bram_addr  <= acc_addr;
              bram_wdata <= acc_wdata;
              bram_we    <= acc_we ? acc_be : 4'd0;
            end else begin
              we_q       <= wbs_we_i;
              bram_addr  <= wbs_adr_i[ADDR_W+1:2];
              bram_wdata <= wbs_dat_i;
              bram_we    <= wbs_we_i ? wbs_sel_i : 4'd0;
            end
          end
        end
        ACCESS: begin
          if (we_q) begin
            state <= DONE;
          end else begin
            state <= WAIT;
            cnt   <= 4'(BRAM_LAT - 1);
          end
        end
        WAIT: begin
          if (cnt == 4'd0) state <= DONE;
          else             cnt   <= cnt - 4'd1;
        end
        DONE: begin
          state    <= IDLE;
          arb_busy <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
